// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 8-bit ALU: latches one instruction, drives the
// ALU for a single EXEC cycle, writes the result back and offers it on a valid/ready port.
module alu_issue_ctrl #(
  parameter int CARRY_CHAIN = 1,
  parameter int NREG        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_f,
  input  logic [7:0]  alu_r,
  input  logic        alu_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_carry,
  output logic        busy
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREG];
  logic              carry;
  logic [1:0]        rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      carry     <= 1'b0;
      rd        <= 2'd0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_f     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready comes up one clock after reset release; only a handshake is accepted
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= EXEC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            rd       <= in_instr[11:10];
            alu_a    <= regs[in_instr[9:8]];
            alu_b    <= in_instr[7:0];
            alu_op   <= in_instr[15:12];
            alu_f    <= (CARRY_CHAIN != 0) ? carry : 1'b0;
          end
        end
        EXEC: begin
          // ALU was read from the old register value; the write lands here, after the read
          state     <= WB;
          regs[rd]  <= alu_r;
          carry     <= alu_d;
          out_data  <= alu_r;
          out_carry <= alu_d;
          out_valid <= 1'b1;
        end
        WB: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter CARRY_CHAIN, default 1: 1 drives alu_f from the stored carry flag, 0 ties alu_f to 0.
REQ-002 SHALL have parameter NREG, default 4: register-file depth; only the value 4 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, instruction present.
REQ-006 SHALL have port in_ready, output, 1, controller can accept an instruction.
REQ-007 SHALL have port in_instr, input, 16, instruction with op=[15:12], rd=[11:10], ra=[9:8], imm=[7:0].
REQ-008 SHALL have port alu_a, output, 8, ALU operand A.
REQ-009 SHALL have port alu_b, output, 8, ALU operand B.
REQ-010 SHALL have port alu_op, output, 4, ALU opcode.
REQ-011 SHALL have port alu_f, output, 1, ALU carry-in.
REQ-012 SHALL have port alu_r, input, 8, ALU result.
REQ-013 SHALL have port alu_d, input, 1, ALU carry-out.
REQ-014 SHALL have port out_valid, output, 1, result available.
REQ-015 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-016 SHALL have port out_data, output, 8, written result.
REQ-017 SHALL have port out_carry, output, 1, written carry.
REQ-018 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE.
REQ-020 In IDLE, in_ready SHALL be 1; when in_valid=1, the instruction SHALL be latched and the state SHALL move to EXEC.
REQ-021 In EXEC and WB, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-022 In EXEC, for exactly one cycle, the ALU ports SHALL be driven as: alu_a=reg[ra], alu_b=imm, alu_op=op unmodified, alu_f=carry flag (CARRY_CHAIN=1) or 0 (CARRY_CHAIN=0).
REQ-023 At the end of EXEC, the controller SHALL capture alu_r and alu_d, then write alu_r into reg[rd] and alu_d into the carry flag.
REQ-024 When rd=ra, the ALU SHALL still see the old register value and the new value SHALL be written afterwards.
REQ-025 In WB, out_valid SHALL be 1 with out_data/out_carry equal to the captured values, held stable until out_ready=1; the FSM SHALL then return to IDLE.
REQ-026 Latency: instruction accepted on edge N -> ALU ports valid after edge N -> out_valid high after edge N+1; with out_ready=1, in_ready SHALL be high again after edge N+2, giving a throughput of one instruction per 3 cycles.
REQ-027 ALU outputs SHALL hold their last EXEC values outside EXEC; the ALU is combinational and is sampled only at the end of EXEC.
REQ-028 Register reads SHALL be purely from the 4x8 register file; no bypass SHALL be provided or needed, since instructions never overlap.
REQ-029 All datapath arithmetic SHALL be performed by the ALU; the controller SHALL perform no arithmetic.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, asynchronously, and regardless of state: set the state to IDLE, clear all registers and the carry flag to 0, and clear out_valid, out_data, out_carry, alu_a, alu_b, alu_op, alu_f and busy to 0.
REQ-031 During reset, in_ready SHALL be 0; it SHALL be 1 from the first clock after rst_n deasserts.
REQ-032 A reset asserted during EXEC or WB SHALL discard the in-flight instruction with no register write and no out_valid pulse.

Verification
REQ-033 Reset check: rst_n low -> all outputs 0; after release, in_ready=1 and busy=0.
REQ-034 Basic issue, ALU stub R=A+B+F for op 0: instr op=0, rd=1, ra=0, imm=3 -> one cycle later alu_a=0, alu_b=3, alu_op=0, alu_f=0 -> next cycle out_valid=1, out_data=3, out_carry=0, and reg1=3 confirmed by a follow-up read with ra=1, imm=0.
REQ-035 Carry chain, CARRY_CHAIN=1: reg0=0xFF via prior op, then op=0, ra=0, imm=1 gives out_data=0x00, out_carry=1 -> next instruction shows alu_f=1; with CARRY_CHAIN=0 the next instruction shows alu_f=0.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in WB -> out_valid stays 1 with data stable, in_ready stays 0, and a pending in_valid is accepted only after the out handshake.
REQ-037 Reset mid-operation: rst_n pulsed low during EXEC -> out_valid never asserts, the target register reads 0, and in_ready=1 after release.
REQ-038 Opcode sweep: op 0..15 issued -> alu_op equals instr[15:12] for each, and the full 4-bit opcode passes through unaltered.
